// File: rtl/alu_issue_stage.sv
// Three-stage ALU issue path: operation queue -> issue register (drives the external
// ALU) -> result register. Every output comes from a register.
module alu_issue_stage #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_a,
    input  logic [7:0]               in_b,
    input  logic [3:0]               in_mode,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    output logic [3:0]               alu_mode,
    input  logic [7:0]               alu_s,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_result,
    output logic [3:0]               out_mode,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               dbgState
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends on ready, and in_ready depends only on the queue count.
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        STALL = 2'd2
    } stateT;

    stateT          state;
    stateT          stateNext;
    logic [7:0]     memA    [DEPTH];
    logic [7:0]     memB    [DEPTH];
    logic [3:0]     memMode [DEPTH];
    logic [AW-1:0]  wrPtr;
    logic [AW-1:0]  rdPtr;
    logic           push;
    logic           pop;
    logic           advance;
    logic           notEmpty;
    logic           loadIssue;
    logic           loadResult;
    logic           unsupported;

    assign in_ready    = (count < FULL);
    assign push        = in_valid && in_ready;
    assign pop         = loadIssue;
    assign notEmpty    = (count != '0);
    assign advance     = !out_valid || out_ready;
    assign unsupported = |alu_mode[3:2];
    assign dbgState    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (notEmpty) stateNext = EXEC;
            end
            EXEC, STALL: begin
                if (!advance)      stateNext = STALL;
                else if (notEmpty) stateNext = EXEC;
                else               stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        loadIssue  = 1'b0;
        loadResult = 1'b0;
        case (state)
            IDLE: begin
                loadIssue = notEmpty;
            end
            EXEC, STALL: begin
                loadResult = advance;
                loadIssue  = advance && notEmpty;
            end
            default: begin
                loadIssue  = 1'b0;
                loadResult = 1'b0;
            end
        endcase
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            memA[wrPtr]    <= in_a;
            memB[wrPtr]    <= in_b;
            memMode[wrPtr] <= in_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_mode <= '0;
        end else if (loadIssue) begin
            alu_a    <= memA[rdPtr];
            alu_b    <= memB[rdPtr];
            alu_mode <= memMode[rdPtr];
        end
    end

    // Unsupported modes still flow through so ordering is preserved; the result is forced to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_mode   <= '0;
            out_err    <= 1'b0;
        end else if (loadResult) begin
            out_valid  <= 1'b1;
            out_result <= unsupported ? 8'h00 : alu_s;
            out_mode   <= alu_mode;
            out_err    <= unsupported;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end
endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter DEPTH, default 4, operation queue depth in entries, power of two, 2..16.
REQ-002 Reset is asynchronous, active-low; one clock.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream offers an operation.
REQ-006 in_ready  output  1  queue can accept an operation this cycle.
REQ-007 in_a  input  8  operand A.
REQ-008 in_b  input  8  operand B.
REQ-009 in_mode  input  4  ALU mode; only 0..3 supported.
REQ-010 alu_a  output  8  operand A to ALU, from issue register.
REQ-011 alu_b  output  8  operand B to ALU, from issue register.
REQ-012 alu_mode  output  4  mode to ALU, from issue register.
REQ-013 alu_s  input  8  combinational ALU result for alu_a/alu_b/alu_mode.
REQ-014 out_valid  output  1  result register holds a result.
REQ-015 out_ready  input  1  downstream accepts the result.
REQ-016 out_result  output  8  captured result.
REQ-017 out_mode  output  4  mode of the captured operation.
REQ-018 out_err  output  1  captured operation had unsupported mode.
REQ-019 count  output  $clog2(DEPTH)+1  queue occupancy.

Function
REQ-020 Three registered stages: queue -> issue register -> result register; all outputs registered.
REQ-021 Push when in_valid and in_ready; in_ready = (count < DEPTH); a pop in the same cycle does not raise in_ready when full.
REQ-022 Queue pointers wrap modulo DEPTH; simultaneous push and pop leaves count unchanged.
REQ-023 Issue FSM states: IDLE (issue register empty), EXEC (issue valid, result register free or draining), STALL (issue valid, result full, out_ready low).
REQ-024 Result register is free when out_valid is 0 or out_ready is 1 (advance condition).
REQ-025 IDLE -> EXEC when queue non-empty: head loads into issue register, popped.
REQ-026 EXEC: at the edge, alu_s, alu_mode and error flag load into result register; if queue non-empty the next head loads into issue register same edge (stay EXEC), else -> IDLE.
REQ-027 EXEC -> STALL when result register not free; STALL holds alu_a/alu_b/alu_mode stable; STALL -> EXEC behaviour at the first edge with out_ready high.
REQ-028 Minimum latency: op pushed at edge N drives ALU after edge N+1, out_valid high after edge N+2.
REQ-029 Sustained throughput one operation per cycle with out_ready held high.
REQ-030 in_mode[3:2] != 0: operation still queued and issued, alu_mode driven as received, out_result = 0x00, out_err = 1.
REQ-031 out_result/out_mode/out_err hold stable while out_valid and not out_ready.
REQ-032 out_valid falls after a handshake edge with no new result loaded.
REQ-033 Operations complete strictly in acceptance order; none dropped or duplicated.

Reset
REQ-034 rst_n low immediately clears: count=0, in_ready=1, FSM=IDLE, out_valid=0, out_err=0, alu_a/alu_b/out_result=0x00, alu_mode/out_mode=0x0.
REQ-035 Reset mid-operation discards all queued, issued and unconsumed results; first op after release follows REQ-028 timing.

Verification
REQ-036 Single op a=0xAB b=0xCB mode=0 pushed at edge 0, bench ALU s=a+b -> alu_a=0xAB after edge 1, out_valid=1 out_result=0x76 out_mode=0 after edge 2.
REQ-037 Back-to-back modes 0,1,2,3 on (0x6F,0xE1), out_ready=1 -> four results in order on consecutive cycles, each equal to bench ALU model.
REQ-038 out_ready=0, push DEPTH+2 ops -> one in result, one in issue (STALL), DEPTH queued, in_ready=0, count=DEPTH; raise out_ready -> all drain in order.
REQ-039 Push mode=0x5 -> out_err=1, out_result=0x00, out_mode=0x5; next op mode=0 -> out_err=0.
REQ-040 Assert rst_n low while 3 ops in flight -> outputs at REQ-034 values without clock edge; after release no stale result appears.
REQ-041 Full queue with simultaneous pop and in_valid=1 -> push refused, count decrements by one.
